// File: rtl/rr_pop_arbiter_d_if.sv
// Pop/stream bundle between the four destination FIFOs, the arbiter and the next stage.
// The master modport is the arbiter side and the slave modport is the environment side.
interface rr_pop_arbiter_d_if #(
  parameter int DATA_SIZE = 6,
  parameter int CNT_SIZE  = 8
);
  logic                 fifo_empty_d0, fifo_empty_d1, fifo_empty_d2, fifo_empty_d3;
  logic [DATA_SIZE-1:0] data_in_d0, data_in_d1, data_in_d2, data_in_d3;
  logic                 pause_in;
  logic                 pop_d0, pop_d1, pop_d2, pop_d3;
  logic                 valid_out;
  logic [DATA_SIZE-1:0] data_out;
  logic [1:0]           dest_out;
  logic [CNT_SIZE-1:0]  word_count;

  modport master (
    input  fifo_empty_d0, fifo_empty_d1, fifo_empty_d2, fifo_empty_d3,
    input  data_in_d0, data_in_d1, data_in_d2, data_in_d3,
    input  pause_in,
    output pop_d0, pop_d1, pop_d2, pop_d3,
    output valid_out, data_out, dest_out, word_count
  );

  modport slave (
    output fifo_empty_d0, fifo_empty_d1, fifo_empty_d2, fifo_empty_d3,
    output data_in_d0, data_in_d1, data_in_d2, data_in_d3,
    output pause_in,
    input  pop_d0, pop_d1, pop_d2, pop_d3,
    input  valid_out, data_out, dest_out, word_count
  );
endinterface

// File: rtl/rr_pop_arbiter_d.sv
// Round-robin pop arbiter over four FIFOs: grants one non-empty FIFO per cycle, captures
// its read data one cycle later and emits it as a registered valid/data/dest stream.
module rr_pop_arbiter_d #(
  parameter int DATA_SIZE = 6,
  parameter int CNT_SIZE  = 8
) (
  input  logic                clk,
  input  logic                reset,
  rr_pop_arbiter_d_if.master  bus
);
  logic [3:0]                empty;
  logic [3:0][DATA_SIZE-1:0] din;
  logic [3:0]                pop;

  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic [1:0]           pend_sel_q;
  logic [1:0]           vld_pipe_q;  // [0] word popped, awaiting data; [1] valid_out
  logic [DATA_SIZE-1:0] data_q;
  logic [1:0]           dest_q;
  logic [CNT_SIZE-1:0]  cnt_q;

  logic       grant;
  logic [1:0] sel;
  logic [1:0] idx;

  assign empty = {bus.fifo_empty_d3, bus.fifo_empty_d2, bus.fifo_empty_d1, bus.fifo_empty_d0};
  assign din   = {bus.data_in_d3, bus.data_in_d2, bus.data_in_d1, bus.data_in_d0};

  // First non-empty FIFO at or after the pointer; pause and reset suppress any grant.
  always_comb begin
    grant = 1'b0;
    sel   = rr_ptr_q;
    idx   = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!grant && !empty[idx]) begin
        grant = 1'b1;
        sel   = idx;
      end
    end
    if (bus.pause_in || reset) grant = 1'b0;
    rr_ptr_d = grant ? sel + 2'd1 : rr_ptr_q;
    pop      = grant ? (4'b0001 << sel) : 4'b0000;
  end

  assign bus.pop_d0 = pop[0];
  assign bus.pop_d1 = pop[1];
  assign bus.pop_d2 = pop[2];
  assign bus.pop_d3 = pop[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      pend_sel_q <= '0;
      vld_pipe_q <= '0;
      data_q     <= '0;
      dest_q     <= '0;
      cnt_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      pend_sel_q <= sel;
      vld_pipe_q <= {vld_pipe_q[0], grant};
      if (vld_pipe_q[0]) begin
        data_q <= din[pend_sel_q];
        dest_q <= pend_sel_q;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.valid_out  = vld_pipe_q[1];
  assign bus.data_out   = data_q;
  assign bus.dest_out   = dest_q;
  assign bus.word_count = cnt_q;
endmodule

// File: tb/tb_rr_pop_arbiter_d.sv
// Scoreboard bench for rr_pop_arbiter_d: queue-based FIFO model and round-robin reference
// drive the DUT; a monitor matches every delivered word against the expected stream.
module tb_rr_pop_arbiter_d;
  logic clk;
  logic rst;
  logic pause;
  logic [3:0] emp;
  logic [5:0] din [4];

  rr_pop_arbiter_d_if #(.DATA_SIZE(6), .CNT_SIZE(8)) bus ();

  rr_pop_arbiter_d #(.DATA_SIZE(6), .CNT_SIZE(8)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  assign bus.fifo_empty_d0 = emp[0];
  assign bus.fifo_empty_d1 = emp[1];
  assign bus.fifo_empty_d2 = emp[2];
  assign bus.fifo_empty_d3 = emp[3];
  assign bus.data_in_d0    = din[0];
  assign bus.data_in_d1    = din[1];
  assign bus.data_in_d2    = din[2];
  assign bus.data_in_d3    = din[3];
  assign bus.pause_in      = pause;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] d;
    logic [1:0] s;
    int         stamp;
  } exp_t;

  logic [5:0] q     [4][$];
  logic [5:0] stage [4][$];
  exp_t       expq[$];

  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  ptr = 0;
  bit  mg = 1'b0;
  int  ms = 0;
  bit  rst_prev = 1'b0;

  int         cnt = 0;
  logic [5:0] last_d = '0;
  logic [1:0] last_s = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  task automatic push(input int k, input logic [5:0] w);
    stage[k].push_back(w);
  endtask

  // One cycle: drive at the falling edge, then predict and check the grant.
  task automatic tick(input logic r, input logic p);
    logic [3:0] exp_pop;
    bit found;
    int j;
    @(negedge clk);
    rst   = r;
    pause = p;
    for (int k = 0; k < 4; k++) begin
      while (stage[k].size() > 0) q[k].push_back(stage[k].pop_front());
      emp[k] = (q[k].size() == 0);
    end
    #1;
    found = 1'b0;
    j = 0;
    if (!r && !p) begin
      for (int k = 0; k < 4; k++) begin
        j = (ptr + k) % 4;
        if (!found && q[j].size() > 0) begin
          found = 1'b1;
          ms = j;
        end
      end
    end
    mg = found;
    exp_pop = found ? (4'b0001 << ms) : 4'b0000;
    chk("pop", 32'({bus.pop_d3, bus.pop_d2, bus.pop_d1, bus.pop_d0}), 32'(exp_pop));
    if (r) ptr = 0;
    else if (found) ptr = (ms + 1) % 4;
  endtask

  // FIFO read side: the granted FIFO presents its head word the cycle after the pop.
  always @(posedge clk) begin
    logic [5:0] w;
    cyc = cyc + 1;
    rst_prev = rst;
    if (mg) begin
      w = q[ms].pop_front();
      din[ms] <= w;
      expq.push_back('{w, 2'(ms), cyc});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_prev) begin
      chk("rst_valid", 32'(bus.valid_out), 32'd0);
      chk("rst_count", 32'(bus.word_count), 32'd0);
      chk("rst_data", 32'(bus.data_out), 32'd0);
      chk("rst_dest", 32'(bus.dest_out), 32'd0);
      expq.delete();
      cnt = 0;
      last_d = '0;
      last_s = '0;
    end else if (bus.valid_out) begin
      if (expq.size() == 0) begin
        chk("spurious_valid", 32'(bus.valid_out), 32'd0);
      end else begin
        e = expq.pop_front();
        cnt = (cnt + 1) % 256;
        chk("data", 32'(bus.data_out), 32'(e.d));
        chk("dest", 32'(bus.dest_out), 32'(e.s));
        chk("latency", 32'(cyc), 32'(e.stamp + 1));
        chk("count", 32'(bus.word_count), 32'(cnt));
        last_d = e.d;
        last_s = e.s;
      end
    end else begin
      chk("hold_data", 32'(bus.data_out), 32'(last_d));
      chk("hold_dest", 32'(bus.dest_out), 32'(last_s));
      chk("idle_count", 32'(bus.word_count), 32'(cnt));
    end
  end

  initial begin
    int guard;
    int pending;
    rst   = 1'b1;
    pause = 1'b0;
    emp   = 4'hF;
    for (int k = 0; k < 4; k++) din[k] = '0;

    // reset held with every FIFO non-empty, then drain in order d0..d3
    for (int k = 0; k < 4; k++) push(k, 6'(6'h21 + k));
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    repeat (6) tick(1'b0, 1'b0);

    // single source d1
    push(1, 6'h05); push(1, 6'h0A); push(1, 6'h3F);
    repeat (6) tick(1'b0, 1'b0);

    // round robin across all four
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) push(k, 6'(6'h10 + k));
    repeat (11) tick(1'b0, 1'b0);

    // pause mid-stream on d2
    for (int i = 0; i < 6; i++) push(2, 6'(6'h30 + i));
    repeat (2) tick(1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b1);
    repeat (7) tick(1'b0, 1'b0);

    // drain to empty on d3, then d0 arrives
    push(3, 6'h1D);
    repeat (3) tick(1'b0, 1'b0);
    push(0, 6'h2E);
    repeat (4) tick(1'b0, 1'b0);

    // reset the cycle after a pop
    push(1, 6'h2A);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);

    // randomized traffic with pause and rare resets; enough words to wrap the counter
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(99) < 35 && q[k].size() < 8) push(k, 6'($urandom_range(63)));
      tick(($urandom_range(199) == 0), ($urandom_range(99) < 15));
    end

    guard = 0;
    pending = 1;
    while (pending != 0 && guard < 200) begin
      tick(1'b0, 1'b0);
      guard++;
      pending = expq.size();
      for (int k = 0; k < 4; k++) pending += q[k].size();
    end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    pending = expq.size();
    for (int k = 0; k < 4; k++) pending += q[k].size();
    chk("drained", 32'(pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
